// File: rtl/rsp_reorder_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : rsp_reorder_buf_if
// Description : Bus bundle between the execution-unit side (issue and
//               response streams), the in-order result consumer and the
//               rsp_reorder_buf block.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   issue_vld / issue_id / issue_rdy  request entering the execution unit
//   rsp_vld / rsp_id / rsp_data       out-of-order response from the unit
//   out_vld / out_id / out_data /     in-order result stream (valid/ready)
//   out_rdy
//   outstanding                       issued, not yet popped entries
//   dup_err / unexp_err               sticky protocol error flags
// Modports:
//   master : environment side (drives issue, response and out_rdy)
//   slave  : reorder buffer side
// ============================================================================
interface rsp_reorder_buf_if #(
  parameter int ID_W   = 3,
  parameter int DATA_W = 64
);

  logic              issue_vld;
  logic [ID_W-1:0]   issue_id;
  logic              issue_rdy;

  logic              rsp_vld;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_data;

  logic              out_vld;
  logic [ID_W-1:0]   out_id;
  logic [DATA_W-1:0] out_data;
  logic              out_rdy;

  logic [ID_W:0]     outstanding;
  logic              dup_err;
  logic              unexp_err;

  modport master (
    output issue_vld, issue_id,
    input  issue_rdy,
    output rsp_vld, rsp_id, rsp_data,
    input  out_vld, out_id, out_data,
    output out_rdy,
    input  outstanding, dup_err, unexp_err
  );

  modport slave (
    input  issue_vld, issue_id,
    output issue_rdy,
    input  rsp_vld, rsp_id, rsp_data,
    output out_vld, out_id, out_data,
    input  out_rdy,
    output outstanding, dup_err, unexp_err
  );

endinterface
`default_nettype wire

// File: rtl/rsp_reorder_buf.sv
`default_nettype none
// ============================================================================
// Module      : rsp_reorder_buf
// Description : Records request IDs in issue order, captures out-of-order
//               execution-unit responses by ID and releases the results
//               strictly in issue order over a valid/ready interface.
//               Flags duplicate issue of an outstanding ID and responses for
//               IDs that are not outstanding (or already completed).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk    clock
//   rst_b  asynchronous active-low reset
//   bus    rsp_reorder_buf_if.slave
//            issue_vld/issue_id -> issue_rdy   (accept on vld && rdy)
//            rsp_vld/rsp_id/rsp_data           (no backpressure)
//            out_vld/out_id/out_data <- out_rdy (pop on vld && rdy)
//            outstanding, dup_err, unexp_err
// Parameters:
//   ID_W    width of request/response IDs; DEPTH = 2**ID_W entries
//   DATA_W  width of result data
// ============================================================================
module rsp_reorder_buf #(
  parameter int ID_W   = 3,
  parameter int DATA_W = 64
) (
  input  wire logic        clk,
  input  wire logic        rst_b,
  rsp_reorder_buf_if.slave bus
);

  localparam int               DEPTH    = 1 << ID_W;
  localparam int               PTR_W    = ID_W + 1;
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // Order FIFO: one extra pointer bit distinguishes full from empty.
  logic [ID_W-1:0]   fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  // Per-ID tables. busy: issued and not yet popped. done: response captured.
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DATA_W-1:0] data_q [DEPTH];

  logic              dup_err_q, dup_err_d;
  logic              unexp_err_q, unexp_err_d;

  // --------------------------------------------------------------------------
  // Derived control
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0]  cnt;
  logic              empty;
  logic              issue_rdy;
  logic [ID_W-1:0]   head;
  logic              out_vld;
  logic              pop;
  logic              issue_hs;
  logic              issue_acc;
  logic              issue_dup;
  logic              rsp_ok;
  logic              rsp_bad;

  // Pointer difference is the occupancy; it never exceeds DEPTH because
  // pushes are gated by issue_rdy.
  assign cnt       = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign issue_rdy = (cnt < FULL_CNT);

  assign head      = fifo_q[rd_ptr_q[ID_W-1:0]];
  assign out_vld   = !empty && done_q[head];
  assign pop       = out_vld && bus.out_rdy;

  // The duplicate check only applies to an issue that completes its
  // handshake; a refused issue (buffer full) is simply not taken.
  // busy is sampled before this cycle's pop, so re-issuing the ID being
  // popped this very cycle is still a duplicate.
  assign issue_hs  = bus.issue_vld && issue_rdy;
  assign issue_dup = issue_hs && busy_q[bus.issue_id];
  assign issue_acc = issue_hs && !busy_q[bus.issue_id];

  // busy is sampled before this cycle's issue, so a response for an ID
  // issued in the same cycle is unexpected. An entry being popped is done,
  // so a response to it is rejected as well.
  assign rsp_ok    = bus.rsp_vld && busy_q[bus.rsp_id] && !done_q[bus.rsp_id];
  assign rsp_bad   = bus.rsp_vld && !rsp_ok;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // Pop, accepted issue and accepted response always touch distinct IDs:
  // issue needs busy=0, response needs busy=1 && done=0, pop needs done=1.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    busy_d      = busy_q;
    done_d      = done_q;
    dup_err_d   = dup_err_q;
    unexp_err_d = unexp_err_q;

    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      busy_d[head] = 1'b0;
      done_d[head] = 1'b0;
    end

    if (issue_acc) begin
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      busy_d[bus.issue_id] = 1'b1;
      done_d[bus.issue_id] = 1'b0;
    end

    if (rsp_ok) begin
      done_d[bus.rsp_id] = 1'b1;
    end

    if (issue_dup) begin
      dup_err_d = 1'b1;
    end

    if (rsp_bad) begin
      unexp_err_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      busy_q      <= '0;
      done_q      <= '0;
      dup_err_q   <= 1'b0;
      unexp_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dup_err_q   <= dup_err_d;
      unexp_err_q <= unexp_err_d;
    end
  end

  // Storage arrays are reset too so that out_id/out_data read as zero
  // straight out of reset (the head slot and its data slot are both 0).
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (issue_acc) begin
        fifo_q[wr_ptr_q[ID_W-1:0]] <= bus.issue_id;
      end
      if (rsp_ok) begin
        data_q[bus.rsp_id] <= bus.rsp_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: combinational reads of registered state only. While the head
  // is valid and stalled nothing can write its FIFO slot or its data slot,
  // so out_id/out_data hold.
  // --------------------------------------------------------------------------
  assign bus.issue_rdy   = issue_rdy;
  assign bus.out_vld     = out_vld;
  assign bus.out_id      = head;
  assign bus.out_data    = data_q[head];
  assign bus.outstanding = cnt;
  assign bus.dup_err     = dup_err_q;
  assign bus.unexp_err   = unexp_err_q;

  // --------------------------------------------------------------------------
  // Structural invariants
  // --------------------------------------------------------------------------
  // Every busy ID sits exactly once in the order FIFO.
  a_busy_matches_cnt : assert property (
    @(posedge clk) disable iff (!rst_b) $countones(busy_q) == int'(cnt)
  );

  // A captured response always belongs to an outstanding ID.
  a_done_implies_busy : assert property (
    @(posedge clk) disable iff (!rst_b) (done_q & ~busy_q) == '0
  );

  a_cnt_bounded : assert property (
    @(posedge clk) disable iff (!rst_b) cnt <= FULL_CNT
  );

endmodule
`default_nettype wire

// File: tb/tb_rsp_reorder_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsp_reorder_buf
// Description : Self-checking bench for rsp_reorder_buf. Directed scenarios
//               followed by randomized traffic; a negedge monitor compares
//               the DUT against a queue-based reference of the in-order
//               release rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsp_reorder_buf;

  localparam int ID_W   = 3;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 1 << ID_W;

  logic clk;
  logic rst_b;

  rsp_reorder_buf_if #(.ID_W(ID_W), .DATA_W(DATA_W)) tif ();

  rsp_reorder_buf #(.ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: expected release order is simply the issue order of accepted
  // IDs; completed IDs and their data are tracked per ID.
  logic [ID_W-1:0]   ord_q [$];
  bit                mdone [DEPTH];
  logic [DATA_W-1:0] mdata [DEPTH];
  bit                mdup;
  bit                munexp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_q(input logic [ID_W-1:0] id);
    foreach (ord_q[i]) if (ord_q[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    ord_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      mdone[i] = 1'b0;
      mdata[i] = '0;
    end
    mdup   = 1'b0;
    munexp = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Monitor / scoreboard: compare at negedge, then advance the reference by
  // the inputs that the next rising edge will sample.
  // --------------------------------------------------------------------------
  bit              ev, pop, hs, acc;
  logic [ID_W-1:0] h;

  always @(negedge clk) begin
    if (!rst_b) begin
      m_reset();
      chk("rst_out_vld",     64'(tif.out_vld),     64'd0);
      chk("rst_out_id",      64'(tif.out_id),      64'd0);
      chk("rst_out_data",    64'(tif.out_data),    64'd0);
      chk("rst_issue_rdy",   64'(tif.issue_rdy),   64'd1);
      chk("rst_outstanding", 64'(tif.outstanding), 64'd0);
      chk("rst_dup_err",     64'(tif.dup_err),     64'd0);
      chk("rst_unexp_err",   64'(tif.unexp_err),   64'd0);
    end else begin
      ev = 1'b0;
      if (ord_q.size() != 0) ev = mdone[ord_q[0]];
      chk("out_vld", 64'(tif.out_vld), 64'(ev));
      if (ev) begin
        chk("out_id",   64'(tif.out_id), 64'(ord_q[0]));
        chk("out_data", tif.out_data,    mdata[ord_q[0]]);
      end
      chk("issue_rdy",   64'(tif.issue_rdy),   64'(ord_q.size() < DEPTH));
      chk("outstanding", 64'(tif.outstanding), 64'(ord_q.size()));
      chk("dup_err",     64'(tif.dup_err),     64'(mdup));
      chk("unexp_err",   64'(tif.unexp_err),   64'(munexp));

      pop = ev && tif.out_rdy;
      hs  = tif.issue_vld && (ord_q.size() < DEPTH);
      acc = hs && !in_q(tif.issue_id);
      if (hs && !acc) mdup = 1'b1;
      if (tif.rsp_vld) begin
        if (in_q(tif.rsp_id) && !mdone[tif.rsp_id]) begin
          mdone[tif.rsp_id] = 1'b1;
          mdata[tif.rsp_id] = tif.rsp_data;
        end else begin
          munexp = 1'b1;
        end
      end
      if (pop) begin
        h = ord_q.pop_front();
        mdone[h] = 1'b0;
      end
      if (acc) begin
        ord_q.push_back(tif.issue_id);
        mdone[tif.issue_id] = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver helpers: apply inputs just after a rising edge, hold for a cycle.
  // --------------------------------------------------------------------------
  task automatic step(input bit iv, input logic [ID_W-1:0] iid,
                      input bit rv, input logic [ID_W-1:0] rid,
                      input logic [DATA_W-1:0] rd, input bit ordy);
    tif.issue_vld = iv;
    tif.issue_id  = iid;
    tif.rsp_vld   = rv;
    tif.rsp_id    = rid;
    tif.rsp_data  = rd;
    tif.out_rdy   = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, '0, 1'b0, '0, '0, ordy);
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && ord_q.size() != 0; c++) idle(1'b1);
    chk("drain_empty", 64'(ord_q.size()), 64'd0);
  endtask

  // Pick a pending (issued, not yet responded) ID from the reference.
  task automatic pick_pending(output bit found, output logic [ID_W-1:0] id);
    logic [ID_W-1:0] pend [$];
    foreach (ord_q[i]) if (!mdone[ord_q[i]]) pend.push_back(ord_q[i]);
    found = (pend.size() != 0);
    id    = found ? pend[$urandom_range(pend.size() - 1)] : '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  bit                r_iv, r_rv, r_ordy, found;
  logic [ID_W-1:0]   r_iid, r_rid;
  logic [DATA_W-1:0] r_rd;

  initial begin
    tif.issue_vld = 1'b0;
    tif.issue_id  = '0;
    tif.rsp_vld   = 1'b0;
    tif.rsp_id    = '0;
    tif.rsp_data  = '0;
    tif.out_rdy   = 1'b0;
    rst_b         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;

    // In-order single transaction.
    step(1'b1, 3'd2, 1'b0, 3'd0, 64'h0, 1'b1);
    idle(1'b1);
    step(1'b0, 3'd0, 1'b1, 3'd2, 64'h1234, 1'b1);
    chk("single_vld",  64'(tif.out_vld),  64'd1);
    chk("single_id",   64'(tif.out_id),   64'd2);
    chk("single_data", tif.out_data,      64'h1234);
    idle(1'b1);
    chk("single_outstanding", 64'(tif.outstanding), 64'd0);

    // Reorder: responses 3, 1, 2 for issues 1, 2, 3.
    for (int i = 1; i <= 3; i++) step(1'b1, 3'(i), 1'b0, 3'd0, 64'h0, 1'b1);
    step(1'b0, 3'd0, 1'b1, 3'd3, 64'h33, 1'b1);
    chk("reorder_wait_head", 64'(tif.out_vld), 64'd0);
    step(1'b0, 3'd0, 1'b1, 3'd1, 64'h11, 1'b1);
    step(1'b0, 3'd0, 1'b1, 3'd2, 64'h22, 1'b1);
    drain();

    // Full, refused 9th issue, then wrap.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 3'(i), 1'b0, 3'd0, 64'h0, 1'b1);
    chk("full_outstanding", 64'(tif.outstanding), 64'd8);
    chk("full_issue_rdy",   64'(tif.issue_rdy),   64'd0);
    step(1'b1, 3'd0, 1'b0, 3'd0, 64'h0, 1'b0);
    chk("full_9th_ignored", 64'(tif.outstanding), 64'd8);
    for (int i = DEPTH - 1; i >= 0; i--) step(1'b0, 3'd0, 1'b1, 3'(i), 64'hA0 + 64'(i), 1'b0);
    drain();
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 1'b0, 3'd0, 64'h0, 1'b1);
    for (int i = 3; i >= 0; i--) step(1'b0, 3'd0, 1'b1, 3'(i), 64'hB0 + 64'(i), 1'b1);
    drain();

    // Backpressure: hold 5 cycles, pop on the 6th.
    step(1'b1, 3'd5, 1'b0, 3'd0, 64'h0, 1'b0);
    step(1'b0, 3'd0, 1'b1, 3'd5, 64'hDEAD_BEEF_0000_0005, 1'b0);
    for (int c = 0; c < 5; c++) begin
      idle(1'b0);
      chk("bp_vld",  64'(tif.out_vld), 64'd1);
      chk("bp_id",   64'(tif.out_id),  64'd5);
      chk("bp_data", tif.out_data,     64'hDEAD_BEEF_0000_0005);
    end
    idle(1'b1);
    chk("bp_popped", 64'(tif.outstanding), 64'd0);

    // Protocol errors.
    step(1'b1, 3'd4, 1'b0, 3'd0, 64'h0, 1'b0);
    step(1'b1, 3'd4, 1'b0, 3'd0, 64'h0, 1'b0);
    chk("dup_err_set", 64'(tif.dup_err), 64'd1);
    chk("dup_dropped", 64'(tif.outstanding), 64'd1);
    step(1'b0, 3'd0, 1'b1, 3'd6, 64'h66, 1'b0);
    chk("unexp_err_set", 64'(tif.unexp_err), 64'd1);
    step(1'b0, 3'd0, 1'b1, 3'd4, 64'h44, 1'b0);
    step(1'b0, 3'd0, 1'b1, 3'd4, 64'h99, 1'b0);
    chk("unexp_err_sticky", 64'(tif.unexp_err), 64'd1);
    chk("second_rsp_ignored", tif.out_data, 64'h44);
    drain();

    // Reset mid-operation: 3 outstanding, one done.
    for (int i = 1; i <= 3; i++) step(1'b1, 3'(i), 1'b0, 3'd0, 64'h0, 1'b0);
    step(1'b0, 3'd0, 1'b1, 3'd2, 64'h77, 1'b0);
    rst_b = 1'b0;
    idle(1'b0);
    rst_b = 1'b1;
    chk("mid_rst_vld",         64'(tif.out_vld),     64'd0);
    chk("mid_rst_outstanding", 64'(tif.outstanding), 64'd0);
    chk("mid_rst_issue_rdy",   64'(tif.issue_rdy),   64'd1);
    chk("mid_rst_errors",      64'({tif.dup_err, tif.unexp_err}), 64'd0);
    step(1'b1, 3'd6, 1'b0, 3'd0, 64'h0, 1'b0);
    step(1'b0, 3'd0, 1'b1, 3'd6, 64'h600D, 1'b0);
    chk("post_rst_data", tif.out_data, 64'h600D);
    drain();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      r_iv  = ($urandom % 3) != 0;
      r_iid = 3'($urandom);
      if (($urandom % 10) != 0) begin
        for (int k = 0; k < DEPTH && in_q(r_iid); k++) r_iid = r_iid + 3'd1;
      end
      r_rv  = 1'b0;
      r_rid = '0;
      r_rd  = {$urandom, $urandom};
      if (($urandom % 20) == 0) begin
        r_rv  = 1'b1;
        r_rid = 3'($urandom);
      end else if (($urandom % 2) == 0) begin
        pick_pending(found, r_rid);
        r_rv = found;
      end
      r_ordy = ($urandom % 4) != 0;
      step(r_iv, r_iid, r_rv, r_rid, r_rd, r_ordy);
    end

    // Respond to everything still pending and empty the buffer.
    for (int c = 0; c < 200 && ord_q.size() != 0; c++) begin
      pick_pending(found, r_rid);
      step(1'b0, 3'd0, found, r_rid, {$urandom, $urandom}, 1'b1);
    end
    chk("final_empty", 64'(ord_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
